// File: rtl/regf_scoreboard.sv
// Purpose: tracks rd of in-flight long ops (load, mul/div) and stalls decode on uncovered RAW/WAW hazards or when the op table is full.
// Latency: stall is combinational, with zero latency. pending_mask, outstanding, stall_cycles and protocol_err are registered and update on the next rising edge.
// Backpressure: stall holds decode. A same-cycle long writeback unmasks its register, so the dependent op issues in that cycle.
module regf_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rs1_addr,
    input  logic          issue_rs1_used,
    input  logic [4:0]    issue_rs2_addr,
    input  logic          issue_rs2_used,
    input  logic [4:0]    issue_rd_addr,
    input  logic          issue_regf_we,
    input  logic          issue_long,
    input  logic          flush,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd_addr,
    input  logic          wb_long,
    output logic          stall,
    output logic [31:0]   pending_mask,
    output logic [CW-1:0] outstanding,
    output logic [31:0]   stall_cycles,
    output logic          protocol_err
);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] MAX_V = CW1'(MAX_OUTSTANDING);

    logic [31:1]   pending_q, pending_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;
    logic          protocol_err_q, protocol_err_d;

    logic [31:0] pend_full, clr_vec, set_vec, eff, next_full;
    logic [CW:0] occ_eff;
    logic        clr, raw1, raw2, waw, full, stall_c, fire, set;

    // Hazard detection against pending state minus the same-cycle clear, plus next-state computation.
    always_comb begin
        pend_full      = {pending_q, 1'b0};
        clr            = wb_valid && wb_long && (wb_rd_addr != 5'd0) && pend_full[wb_rd_addr];
        clr_vec        = clr ? (32'd1 << wb_rd_addr) : 32'd0;
        // Writeback data reaches decode through the forwarding path, so a clearing register no longer blocks.
        eff            = pend_full & ~clr_vec;
        raw1           = issue_rs1_used && (issue_rs1_addr != 5'd0) && eff[issue_rs1_addr];
        raw2           = issue_rs2_used && (issue_rs2_addr != 5'd0) && eff[issue_rs2_addr];
        waw            = issue_regf_we && (issue_rd_addr != 5'd0) && eff[issue_rd_addr];
        occ_eff        = {1'b0, outstanding_q} - {{CW{1'b0}}, clr};
        full           = issue_long && issue_regf_we && (issue_rd_addr != 5'd0) && (occ_eff == MAX_V);
        stall_c        = issue_valid && !flush && (raw1 || raw2 || waw || full);
        fire           = issue_valid && !stall_c && !flush;
        set            = fire && issue_long && issue_regf_we && (issue_rd_addr != 5'd0);
        set_vec        = set ? (32'd1 << issue_rd_addr) : 32'd0;
        // If set and clear hit the same register, set wins and the bit stays pending.
        next_full      = eff | set_vec;
        pending_d      = next_full[31:1];
        // set is refused while full, so the counter cannot exceed MAX or drop below zero.
        outstanding_d  = outstanding_q + CW'(set) - CW'(clr);
        protocol_err_d = protocol_err_q || (wb_valid && wb_long && !clr);
        stall_cycles_d = (stall_c && (stall_cycles_q != 32'hFFFF_FFFF)) ? stall_cycles_q + 32'd1
                                                                        : stall_cycles_q;
    end

    // State registers. The asynchronous reset drops all in-flight tracking immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            outstanding_q  <= '0;
            stall_cycles_q <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            outstanding_q  <= outstanding_d;
            stall_cycles_q <= stall_cycles_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign stall        = stall_c;
    assign pending_mask = {pending_q, 1'b0};
    assign outstanding  = outstanding_q;
    assign stall_cycles = stall_cycles_q;
    assign protocol_err = protocol_err_q;
endmodule

// File: doc/regf_scoreboard.md
# regf_scoreboard

Register-file scoreboard for the rv32imc pipeline. It tracks destination registers of in-flight long-latency operations (loads, mul/div) from issue until writeback, and raises a decode stall on RAW or WAW hazards the forwarding network cannot cover. It sits beside the decode stage. Issue-side register addresses come in, writeback completions come back from the tail of the pipe, and it produces `stall` plus pending state for debug and performance counters.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum simultaneously pending long ops (1..31).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: decode holds a valid instruction.
- `issue_rs1_addr` input 5: source register 1.
- `issue_rs1_used` input 1: instruction reads rs1.
- `issue_rs2_addr` input 5: source register 2.
- `issue_rs2_used` input 1: instruction reads rs2.
- `issue_rd_addr` input 5: destination register.
- `issue_regf_we` input 1: instruction writes rd.
- `issue_long` input 1: instruction is a long-latency op.
- `flush` input 1: kill the decode instruction this cycle; no issue occurs.
- `wb_valid` input 1: writeback this cycle.
- `wb_rd_addr` input 5: writeback destination.
- `wb_long` input 1: writeback completes a long op.
- `stall` output 1: hold decode this cycle.
- `pending_mask` output 32: bit n set means xn has an outstanding long write.
- `outstanding` output $clog2(MAX_OUTSTANDING+1): count of set pending bits.
- `stall_cycles` output 32: saturating count of cycles with `stall`=1.
- `protocol_err` output 1: sticky flag for an unexpected long writeback.

## Operation
- Register state: `pending[31:1]`. `pending_mask[0]` is always 0.
- `clr` = `wb_valid` && `wb_long` && `pending[wb_rd_addr]` && `wb_rd_addr`!=0.
- Effective pending = `pending` with the `clr` bit masked. Writeback data reaches decode through the forwarding path in the same cycle.
- `raw1` = `issue_rs1_used` && rs1!=0 && effective pending[rs1]. `raw2` is the same for rs2.
- `waw` = `issue_regf_we` && rd!=0 && effective pending[rd].
- `full` = `issue_long` && `issue_regf_we` && rd!=0 && (`outstanding` − `clr`) == `MAX_OUTSTANDING`.
- `stall` = `issue_valid` && !`flush` && (`raw1` | `raw2` | `waw` | `full`). The output is combinational.
- Issue fires when `issue_valid` && !`stall` && !`flush`.
- `set` = fire && `issue_long` && `issue_regf_we` && rd!=0. It sets `pending[rd]`.
- `set` and `clr` can hit the same register in one cycle. `waw` is masked by the clear, so the register may be reissued; `set` wins and the bit stays 1.
- `outstanding` next = `outstanding` + `set` − `clr`. The counter is never allowed to wrap.
- A long writeback to x0, or to a register that is not pending, has no effect on `pending` or `outstanding` and sets `protocol_err`. The flag is sticky until reset.
- Short-op writebacks (`wb_long`=0) are ignored.
- `flush` only suppresses this cycle's issue. In-flight long ops still write back and clear their bits normally.
- `stall_cycles` increments every cycle `stall`=1 and holds at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous on `rst_n` low) clears `pending`, `outstanding`, `stall_cycles` and `protocol_err` to 0. `stall` = 0 while `issue_valid` = 0.
- Reset asserted mid-operation drops all pending state immediately. Writebacks that arrive after reset flag `protocol_err`; this is required behaviour.
- `stall` is combinational from the current-cycle inputs and registered state, with zero latency.
- `pending_mask` and `outstanding` update on the rising edge after the set or clear and are registered outputs.
- A dependent instruction sees `stall`=0 in the same cycle its producer's long writeback occurs.
- The decode stage must hold all `issue_*` inputs stable while `stall`=1.

## Test plan
- Load-use: issue a long op with rd=5, then issue an op with rs1=5. Required: `stall`=1 until the cycle `wb_valid`/`wb_long` arrive with rd=5. In that cycle `stall`=0 and the op issues. Then `pending_mask`=0 and `outstanding`=0.
- WAW plus same-cycle reissue: x7 is pending. Issue a long op with rd=7 in the cycle wb clears x7. Required: no stall, `pending_mask[7]` stays 1, `outstanding` unchanged at 1.
- Capacity, with `MAX_OUTSTANDING`=4: issue long ops to x1–x4, then a fifth long op to x6. Required: `stall`=1 with `outstanding`=4. A wb to x2 in some cycle lets the fifth op issue in that same cycle; the next cycle `outstanding`=4 and `pending_mask`=0x5A.
- x0 and unused sources: issue a long op with rd=0, or an op with rs2=3 and `issue_rs2_used`=0 while x3 is pending. Required: no pending bit set and `stall`=0.
- Flush and error: x9 is pending and `flush`=1 on a dependent op. Required: `stall`=0, no set. Then a long wb to x12, which is not pending. Required: `protocol_err`=1 and it stays set.
- Reset mid-flight: with 3 pending, drop `rst_n` asynchronously. Required: all outputs 0 immediately. Sustain `stall` for 40 cycles. Required: `stall_cycles`=40.
